// File: rtl/dmem_bridge.sv
// Memory-stage data bridge: turns pipeline loads/stores into a req/ack bus handshake with a bus timeout.
// Define DMEM_WBUF_EN to add a one-entry posted write buffer that acks stores early and drains on its own.
module dmem_bridge #(
   parameter int TO_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_M,
   input  logic        we_M,
   input  logic [31:0] addr_M,
   input  logic [31:0] wdata_M,
   input  logic [3:0]  byte_en_M,
   output logic [31:0] read_data_M,
   output logic        data_mem_ack,
   output logic        bus_req,
   output logic        bus_we,
   output logic [29:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic        bus_err
);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   localparam logic [9:0] TO_LAST = 10'(TO_CYCLES - 1);

   state_t      state;
   state_t      state_next;
   logic [29:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  be_q;
   logic [9:0]  to_cnt;
   logic        accept;
   logic        timeout;
   logic        unused_addr_lsbs;

   assign unused_addr_lsbs = ^addr_M[1:0];

`ifdef DMEM_WBUF_EN
   logic wbuf_valid;
   // A pending drain owns the bus, so new accesses stall in IDLE until it has finished.
   assign accept = (state == IDLE) && req_M && !wbuf_valid;
`else
   assign accept = (state == IDLE) && req_M;
`endif

   // An ack on the last allowed cycle wins over the timeout.
   assign timeout = bus_req && !bus_ack && (to_cnt == TO_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
`ifdef DMEM_WBUF_EN
               state_next = we_M ? DONE : RD;
`else
               state_next = we_M ? WR : RD;
`endif
            end
         end
         RD, WR:  if (bus_ack || timeout) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus_req      = 1'b0;
      bus_we       = 1'b0;
      bus_be       = 4'h0;
      data_mem_ack = 1'b0;
      case (state)
         RD: begin
            bus_req = 1'b1;
            bus_be  = 4'hF;
         end
         WR: begin
            bus_req = 1'b1;
            bus_we  = 1'b1;
            bus_be  = be_q;
         end
         DONE:    data_mem_ack = 1'b1;
         default: ;
      endcase
`ifdef DMEM_WBUF_EN
      if (wbuf_valid) begin
         bus_req = 1'b1;
         bus_we  = 1'b1;
         bus_be  = be_q;
      end
`endif
   end

   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;

   // Request fields, timeout counter, load data and the error pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q      <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
         to_cnt      <= '0;
         read_data_M <= '0;
         bus_err     <= 1'b0;
      end else begin
         bus_err <= timeout;
         if (!bus_req || bus_ack || timeout) to_cnt <= '0;
         else                                to_cnt <= to_cnt + 10'd1;
         if (accept) begin
            addr_q  <= addr_M[31:2];
            wdata_q <= wdata_M;
            be_q    <= byte_en_M;
         end
         if (state == RD && bus_ack)                       read_data_M <= bus_rdata;
         else if ((state == RD || state == WR) && timeout) read_data_M <= '0;
      end
   end

`ifdef DMEM_WBUF_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                  wbuf_valid <= 1'b0;
      else if (accept && we_M)                     wbuf_valid <= 1'b1;
      else if (wbuf_valid && (bus_ack || timeout)) wbuf_valid <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: default-timeout instance plus a TO_CYCLES=4 instance for timeout cases.
module tb_dmem_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_M, we_M, bus_ack;
   logic [31:0] addr_M, wdata_M, bus_rdata;
   logic [3:0]  byte_en_M;

   logic [31:0] read_data_M, bus_wdata;
   logic        data_mem_ack, bus_req, bus_we, bus_err;
   logic [29:0] bus_addr;
   logic [3:0]  bus_be;

   logic [31:0] to_read_data, to_bus_wdata;
   logic        to_ack, to_bus_req, to_bus_we, to_bus_err;
   logic [29:0] to_bus_addr;
   logic [3:0]  to_bus_be;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   dmem_bridge dut (
      .clk(clk), .reset(reset), .req_M(req_M), .we_M(we_M), .addr_M(addr_M),
      .wdata_M(wdata_M), .byte_en_M(byte_en_M), .read_data_M(read_data_M),
      .data_mem_ack(data_mem_ack), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
      .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
   );

   dmem_bridge #(.TO_CYCLES(4)) dut_to (
      .clk(clk), .reset(reset), .req_M(req_M), .we_M(we_M), .addr_M(addr_M),
      .wdata_M(wdata_M), .byte_en_M(byte_en_M), .read_data_M(to_read_data),
      .data_mem_ack(to_ack), .bus_req(to_bus_req), .bus_we(to_bus_we),
      .bus_addr(to_bus_addr), .bus_wdata(to_bus_wdata), .bus_be(to_bus_be),
      .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(to_bus_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req_M = 1'b0; we_M = 1'b0; addr_M = '0; wdata_M = '0;
      byte_en_M = '0; bus_ack = 1'b0; bus_rdata = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      logic [104:0] outs;
      clear_inputs();
      reset = 1'b0;
      tick();
      addr_M = 32'hFFFF_FFFC; wdata_M = 32'h5555_AAAA; byte_en_M = 4'hF;
      tick();
      outs = {read_data_M, data_mem_ack, bus_req, bus_we, bus_addr, bus_wdata, bus_be, bus_err};
      n_cmp++;
      if (outs !== '0) begin n_bad++; $display("[TB] FAIL reset_outs: got %h expected 0", outs); end
      outs = {to_read_data, to_ack, to_bus_req, to_bus_we, to_bus_addr, to_bus_wdata, to_bus_be, to_bus_err};
      n_cmp++;
      if (outs !== '0) begin n_bad++; $display("[TB] FAIL reset_outs_to: got %h expected 0", outs); end
      reset = 1'b1;
      tick();
      n_cmp++;
      if ({bus_req, data_mem_ack} !== 2'b00) begin n_bad++; $display("[TB] FAIL post_reset_idle: got %b expected 00", {bus_req, data_mem_ack}); end
   endtask

   task automatic test_load();
      do_reset();
      req_M = 1'b1; we_M = 1'b0; addr_M = 32'h0000_1004; byte_en_M = 4'b0010;
      n_cmp++;
      if (bus_req !== 1'b0) begin n_bad++; $display("[TB] FAIL load_req_cycle1: got %b expected 0", bus_req); end
      tick();
      req_M = 1'b0;
      n_cmp++;
      if ({bus_req, bus_we, bus_be, bus_addr, data_mem_ack} !== {1'b1, 1'b0, 4'hF, 30'h401, 1'b0}) begin
         n_bad++;
         $display("[TB] FAIL load_bus: got req=%b we=%b be=%h addr=%h ack=%b expected 1 0 f 0000401 0", bus_req, bus_we, bus_be, bus_addr, data_mem_ack);
      end
      bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
      tick();
      bus_ack = 1'b0; bus_rdata = '0;
      n_cmp++;
      if ({data_mem_ack, bus_req, bus_err} !== 3'b100) begin n_bad++; $display("[TB] FAIL load_ack_cycle3: got ack/req/err=%b expected 100", {data_mem_ack, bus_req, bus_err}); end
      n_cmp++;
      if (read_data_M !== 32'hCAFE_F00D) begin n_bad++; $display("[TB] FAIL load_data: got %h expected cafef00d", read_data_M); end
      tick();
      n_cmp++;
      if ({data_mem_ack, read_data_M} !== {1'b0, 32'hCAFE_F00D}) begin n_bad++; $display("[TB] FAIL load_ack_single: got ack=%b data=%h expected 0 cafef00d", data_mem_ack, read_data_M); end
   endtask

`ifndef DMEM_WBUF_EN
   task automatic test_store();
      do_reset();
      req_M = 1'b1; we_M = 1'b1; addr_M = 32'h0000_2008; wdata_M = 32'h1122_3344; byte_en_M = 4'b0011;
      tick();
      req_M = 1'b0; we_M = 1'b0; addr_M = '0; wdata_M = '0; byte_en_M = '0;
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata, data_mem_ack} !== {1'b1, 1'b1, 4'b0011, 30'h802, 32'h1122_3344, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL store_wait%0d: got req=%b we=%b be=%b addr=%h wdata=%h ack=%b expected 1 1 0011 0000802 11223344 0", i, bus_req, bus_we, bus_be, bus_addr, bus_wdata, data_mem_ack);
         end
         if (i == 5) bus_ack = 1'b1;
         tick();
      end
      bus_ack = 1'b0;
      n_cmp++;
      if ({data_mem_ack, bus_req, bus_err} !== 3'b100) begin n_bad++; $display("[TB] FAIL store_ack: got ack/req/err=%b expected 100", {data_mem_ack, bus_req, bus_err}); end
      tick();
      n_cmp++;
      if (data_mem_ack !== 1'b0) begin n_bad++; $display("[TB] FAIL store_ack_single: got %b expected 0", data_mem_ack); end
   endtask
`endif

   task automatic test_timeout();
      do_reset();
      req_M = 1'b1; addr_M = 32'h0000_0030;
      tick();
      req_M = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hA5A5_A5A5;
      tick();
      bus_ack = 1'b0;
      tick();
      n_cmp++;
      if (to_read_data !== 32'hA5A5_A5A5) begin n_bad++; $display("[TB] FAIL to_preload: got %h expected a5a5a5a5", to_read_data); end
      // ack arrives in the 4th request cycle: must win over the timeout
      req_M = 1'b1; addr_M = 32'h0000_0034;
      tick();
      req_M = 1'b0;
      tick(); tick(); tick();
      n_cmp++;
      if (to_bus_req !== 1'b1) begin n_bad++; $display("[TB] FAIL to_edge_req: got %b expected 1", to_bus_req); end
      bus_ack = 1'b1; bus_rdata = 32'h5A5A_5A5A;
      tick();
      bus_ack = 1'b0;
      n_cmp++;
      if ({to_ack, to_bus_err, to_read_data} !== {1'b1, 1'b0, 32'h5A5A_5A5A}) begin
         n_bad++;
         $display("[TB] FAIL to_edge_ack: got ack=%b err=%b data=%h expected 1 0 5a5a5a5a", to_ack, to_bus_err, to_read_data);
      end
      tick();
      req_M = 1'b1; addr_M = 32'h0000_0038;
      tick();
      req_M = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if ({to_bus_req, to_bus_err, to_ack} !== 3'b100) begin n_bad++; $display("[TB] FAIL to_wait%0d: got req/err/ack=%b expected 100", i, {to_bus_req, to_bus_err, to_ack}); end
         tick();
      end
      n_cmp++;
      if ({to_bus_req, to_bus_err, to_ack, to_read_data} !== {3'b011, 32'h0}) begin
         n_bad++;
         $display("[TB] FAIL to_expire: got req=%b err=%b ack=%b data=%h expected 0 1 1 00000000", to_bus_req, to_bus_err, to_ack, to_read_data);
      end
      tick();
      n_cmp++;
      if ({to_bus_err, to_ack} !== 2'b00) begin n_bad++; $display("[TB] FAIL to_pulse_single: got err/ack=%b expected 00", {to_bus_err, to_ack}); end
   endtask

   task automatic test_reset_mid();
      logic [104:0] outs;
      do_reset();
      req_M = 1'b1; addr_M = 32'h0000_0100;
      tick();
      req_M = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
      tick();
      bus_ack = 1'b0;
      tick();
      req_M = 1'b1; addr_M = 32'h0000_0104;
      tick();
      req_M = 1'b0;
      n_cmp++;
      if ({bus_req, read_data_M} !== {1'b1, 32'h1234_5678}) begin n_bad++; $display("[TB] FAIL mid_pre: got req=%b data=%h expected 1 12345678", bus_req, read_data_M); end
      #2 reset = 1'b0;
      #1;
      outs = {read_data_M, data_mem_ack, bus_req, bus_we, bus_addr, bus_wdata, bus_be, bus_err};
      n_cmp++;
      if (outs !== '0) begin n_bad++; $display("[TB] FAIL mid_async_clear: got %h expected 0", outs); end
      bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
      tick();
      tick();
      outs = {read_data_M, data_mem_ack, bus_req, bus_we, bus_addr, bus_wdata, bus_be, bus_err};
      n_cmp++;
      if (outs !== '0) begin n_bad++; $display("[TB] FAIL mid_held: got %h expected 0", outs); end
      reset = 1'b1; bus_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if ({data_mem_ack, bus_err, bus_req} !== 3'b000) begin n_bad++; $display("[TB] FAIL mid_abandon%0d: got ack/err/req=%b expected 000", i, {data_mem_ack, bus_err, bus_req}); end
      end
      req_M = 1'b1; addr_M = 32'h0000_0200;
      tick();
      req_M = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
      tick();
      bus_ack = 1'b0;
      n_cmp++;
      if ({data_mem_ack, read_data_M} !== {1'b1, 32'hDEAD_BEEF}) begin n_bad++; $display("[TB] FAIL mid_recover: got ack=%b data=%h expected 1 deadbeef", data_mem_ack, read_data_M); end
      tick();
   endtask

   task automatic test_stray_ack();
      bus_ack = 1'b1; bus_rdata = 32'hFFFF_0000;
      tick();
      tick();
      bus_ack = 1'b0;
      n_cmp++;
      if ({data_mem_ack, bus_err, read_data_M} !== {2'b00, 32'hDEAD_BEEF}) begin
         n_bad++;
         $display("[TB] FAIL stray_ack: got ack=%b err=%b data=%h expected 0 0 deadbeef", data_mem_ack, bus_err, read_data_M);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      req_M = 1'b1; addr_M = 32'h0000_0010;
      tick();
      n_cmp++;
      if ({bus_req, bus_addr} !== {1'b1, 30'h4}) begin n_bad++; $display("[TB] FAIL b2b_first: got req=%b addr=%h expected 1 0000004", bus_req, bus_addr); end
      bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
      tick();
      bus_ack = 1'b0; addr_M = 32'h0000_0020;
      n_cmp++;
      if ({data_mem_ack, read_data_M} !== {1'b1, 32'h1111_1111}) begin n_bad++; $display("[TB] FAIL b2b_ack1: got ack=%b data=%h expected 1 11111111", data_mem_ack, read_data_M); end
      tick();
      n_cmp++;
      if ({bus_req, data_mem_ack} !== 2'b00) begin n_bad++; $display("[TB] FAIL b2b_done_ignores_req: got req/ack=%b expected 00", {bus_req, data_mem_ack}); end
      tick();
      req_M = 1'b0;
      n_cmp++;
      if ({bus_req, bus_addr} !== {1'b1, 30'h8}) begin n_bad++; $display("[TB] FAIL b2b_second: got req=%b addr=%h expected 1 0000008", bus_req, bus_addr); end
      bus_ack = 1'b1; bus_rdata = 32'h2222_2222;
      tick();
      bus_ack = 1'b0;
      n_cmp++;
      if ({data_mem_ack, read_data_M} !== {1'b1, 32'h2222_2222}) begin n_bad++; $display("[TB] FAIL b2b_ack2: got ack=%b data=%h expected 1 22222222", data_mem_ack, read_data_M); end
      tick();
   endtask

`ifdef DMEM_WBUF_EN
   task automatic test_wbuf();
      do_reset();
      req_M = 1'b1; we_M = 1'b1; addr_M = 32'h0000_0040; wdata_M = 32'hA1B2_C3D4; byte_en_M = 4'b1100;
      tick();
      we_M = 1'b0; addr_M = 32'h0000_0080; wdata_M = '0; byte_en_M = '0;
      n_cmp++;
      if ({data_mem_ack, bus_req, bus_we, bus_be, bus_addr, bus_wdata} !== {3'b111, 4'b1100, 30'h10, 32'hA1B2_C3D4}) begin
         n_bad++;
         $display("[TB] FAIL wbuf_early_ack: got ack=%b req=%b we=%b be=%b addr=%h wdata=%h", data_mem_ack, bus_req, bus_we, bus_be, bus_addr, bus_wdata);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++;
         if ({data_mem_ack, bus_req, bus_we, bus_addr} !== {3'b011, 30'h10}) begin
            n_bad++;
            $display("[TB] FAIL wbuf_load_wait%0d: got ack=%b req=%b we=%b addr=%h expected 0 1 1 0000010", i, data_mem_ack, bus_req, bus_we, bus_addr);
         end
      end
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      n_cmp++;
      if ({bus_req, data_mem_ack} !== 2'b00) begin n_bad++; $display("[TB] FAIL wbuf_drained: got req/ack=%b expected 00", {bus_req, data_mem_ack}); end
      tick();
      req_M = 1'b0;
      n_cmp++;
      if ({bus_req, bus_we, bus_be, bus_addr} !== {2'b10, 4'hF, 30'h20}) begin
         n_bad++;
         $display("[TB] FAIL wbuf_load_go: got req=%b we=%b be=%h addr=%h expected 1 0 f 0000020", bus_req, bus_we, bus_be, bus_addr);
      end
      bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
      tick();
      bus_ack = 1'b0;
      n_cmp++;
      if ({data_mem_ack, read_data_M} !== {1'b1, 32'h0BAD_F00D}) begin n_bad++; $display("[TB] FAIL wbuf_load_done: got ack=%b data=%h expected 1 0badf00d", data_mem_ack, read_data_M); end
      tick();
   endtask
`endif

   initial begin
      clear_inputs();
      reset = 1'b1;
      test_reset();
      test_load();
`ifdef DMEM_WBUF_EN
      test_wbuf();
`else
      test_store();
`endif
      test_timeout();
      test_reset_mid();
      test_stray_ack();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 SHALL have parameter: TO_CYCLES, default 255, bus-timeout limit in cycles (legal range 1..1023).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port: req_M  input  1  memory-stage access valid (load or store).
REQ-005 SHALL have port: we_M  input  1  1 = store, 0 = load.
REQ-006 SHALL have port: addr_M  input  32  byte address (alu_out_M).
REQ-007 SHALL have port: wdata_M  input  32  store data, already lane-replicated.
REQ-008 SHALL have port: byte_en_M  input  4  store byte lanes.
REQ-009 SHALL have port: read_data_M  output  32  load data to the pipeline.
REQ-010 SHALL have port: data_mem_ack  output  1  access complete; pipeline may advance.
REQ-011 SHALL have ports: bus_req out 1, bus_we out 1, bus_addr out 30 (word address), bus_wdata out 32, bus_be out 4 (external memory request).
REQ-012 SHALL have ports: bus_rdata in 32, bus_ack in 1 (external memory response).
REQ-013 SHALL have port: bus_err  output  1  one-cycle timeout pulse.

Function
REQ-014 SHALL implement FSM states IDLE, RD, WR, DONE.
REQ-015 IDLE with req_M=1: SHALL register addr_M[31:2], we_M, wdata_M and byte_en_M, then go to RD (load) or WR (store).
REQ-016 RD/WR: SHALL hold bus_req=1 with stable registered fields until bus_ack=1.
REQ-017 bus_we SHALL be 1 only in WR; bus_be SHALL be 4'hF for loads.
REQ-018 On bus_ack in RD: SHALL latch bus_rdata into read_data_M and go to DONE.
REQ-019 On bus_ack in WR: SHALL go to DONE.
REQ-020 DONE: SHALL assert data_mem_ack=1 for exactly one cycle, then go to IDLE; req_M SHALL be ignored in DONE.
REQ-021 Minimum access latency SHALL be 3 cycles from req_M to data_mem_ack, i.e. bus_ack in the first bus_req cycle.
REQ-022 bus_ack arriving while bus_req=0 SHALL be ignored.
REQ-023 A timeout counter SHALL count bus_req cycles without bus_ack.
REQ-024 When the timeout counter reaches TO_CYCLES: SHALL drop bus_req, pulse bus_err, set read_data_M=0, go to DONE.
REQ-025 bus_ack in the same cycle the counter reaches TO_CYCLES SHALL take priority; no bus_err is raised.
REQ-026 read_data_M SHALL hold its value until the next completed load.

Reset
REQ-027 When reset=0: SHALL immediately enter IDLE, regardless of state or an in-flight access.
REQ-028 During reset, all outputs SHALL be 0 and the timeout counter cleared.
REQ-029 An in-flight access interrupted by reset SHALL be abandoned, with no ack and no bus_err.

Configuration
REQ-030 Macro DMEM_WBUF_EN SHALL compile in a one-entry posted write buffer.
REQ-031 With DMEM_WBUF_EN and the buffer empty, a store in IDLE SHALL be captured into the buffer and go directly to DONE (ack 2 cycles after req_M); the buffer then drains over the bus independently.
REQ-032 With DMEM_WBUF_EN, a load or store arriving while the buffer is occupied SHALL wait in IDLE until the drain completes (bus_ack), then proceed normally.
REQ-033 With DMEM_WBUF_EN, a drain timeout SHALL pulse bus_err and discard the entry.
REQ-034 Without DMEM_WBUF_EN, stores SHALL follow REQ-015..REQ-020 unbuffered.

Verification
REQ-035 Load, addr 0x0000_1004, bus_ack on first request cycle, bus_rdata 0xCAFEF00D -> bus_addr 0x0000401, data_mem_ack in cycle 3, read_data_M 0xCAFEF00D.
REQ-036 Store 0x11223344 with byte_en 4'b0011 and 5 wait states -> bus_we=1, bus_be 4'b0011, data_mem_ack one cycle after bus_ack, single pulse.
REQ-037 No bus_ack for TO_CYCLES=4 -> bus_req drops after 4 cycles, bus_err pulse, ack, read_data_M 0.
REQ-038 reset=0 mid-RD -> outputs 0 asynchronously, no ack; next load after reset release completes normally.
REQ-039 DMEM_WBUF_EN: store then immediate load -> store acked in 2 cycles; load bus_req asserted only after the drain bus_ack.
